// File: rtl/alu_logic_arbiter.sv
// alu_logic_arbiter: round-robin sharing of one logic unit between two requesters with a registered response.
// Optional rsp_zero output is enabled by defining ALU_ARB_ZERO_FLAG_EN.
module alu_logic_arbiter #(
  parameter int INIT_PRIO = 0,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_x,
  input  logic [31:0]      req0_y,
  input  logic [1:0]       req0_fn,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_x,
  input  logic [31:0]      req1_y,
  input  logic [1:0]       req1_fn,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_id,
`ifdef ALU_ARB_ZERO_FLAG_EN
  output logic             rsp_zero,
`endif
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_nxt;
  logic prio, can_accept, grant0, grant1, acc;
  logic [31:0] alu_r;
  assign rsp_valid = state == FULL;
  always_comb begin
    can_accept = state == EMPTY || rsp_ready;
    grant0 = req0_valid && (!req1_valid || !prio);
    grant1 = req1_valid && (!req0_valid || prio);
    req0_ready = grant0 && can_accept;
    req1_ready = grant1 && can_accept;
    acc = req0_ready || req1_ready;
    state_nxt = acc ? FULL : (rsp_ready ? EMPTY : state);
  end
  alu_logic_unit u_alu (
    .x  (grant1 ? req1_x : req0_x),
    .y  (grant1 ? req1_y : req0_y),
    .fn (grant1 ? req1_fn : req0_fn),
    .r  (alu_r)
  );
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
      prio <= INIT_PRIO[0];
      rsp_data <= '0;
      rsp_id <= 1'b0;
    end else begin
      state <= state_nxt;
      if (acc) begin
        rsp_data <= alu_r;
        rsp_id <= grant1;
        prio <= !grant1;
      end
    end
  end
`ifdef ALU_ARB_ZERO_FLAG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rsp_zero <= 1'b0;
    else if (acc) rsp_zero <= alu_r == '0;
  end
`endif
  // Counters saturate at all-ones; a clear beats a same-cycle increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else if (cnt_clr) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (req0_ready && gnt_cnt0 != '1) gnt_cnt0 <= gnt_cnt0 + 1'b1;
      if (req1_ready && gnt_cnt1 != '1) gnt_cnt1 <= gnt_cnt1 + 1'b1;
    end
  end
endmodule

module alu_logic_unit (
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic [1:0]  fn,
  output logic [31:0] r
);
  always_comb r = fn == 2'b00 ? x & y : fn == 2'b01 ? x | y : fn == 2'b10 ? x ^ y : ~(x | y);
endmodule
